wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master, one-slave pipelined Wishbone arbiter that shares the single instruction/data memory port between the FETCH stage (master 0) and the MEMORY stage (master 1). It sits between the CPU pipeline and the memory slave. It grants the bus per Wishbone cycle (`cyc` lock) using round-robin fairness, and routes stall and ack back to the owning master. An outstanding-request counter guarantees that ownership never changes while acks are still in flight.

## Interface
- ADDR_WIDTH, 16, address width of all ports
- DATA_WIDTH, 16, data width of all ports
- CNT_WIDTH, 4, outstanding-request counter width; maximum outstanding is 2^CNT_WIDTH-1
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i  in  1 each  master 0 (FETCH) cycle/strobe/write
- m0_wb_addr_i  in  ADDR_WIDTH  master 0 address
- m0_wb_dat_i  in  DATA_WIDTH  master 0 write data
- m0_wb_stall_o, m0_wb_ack_o  out  1 each  master 0 stall/ack
- m0_wb_data_o  out  DATA_WIDTH  master 0 read data
- m1_wb_*  same set as m0  master 1 (MEMORY stage)
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each  slave cycle/strobe/write
- s_wb_addr_o  out  ADDR_WIDTH; s_wb_dat_o  out  DATA_WIDTH  slave address/write data
- s_wb_stall_i, s_wb_ack_i  in  1 each; s_wb_data_i  in  DATA_WIDTH  slave responses
- grant_o  out  2  one-hot owner (bit0=m0, bit1=m1); 00 in IDLE

## Operation
- States: IDLE, GNT0, GNT1. Registers: state, last (last master served), cnt (CNT_WIDTH).
- Reset: state=IDLE, last=1 (m0 wins the first tie), cnt=0.
- IDLE: if only one master has cyc=1, grant it. If both do, grant the master ≠ last. Otherwise stay in IDLE.
- GNTx: slave addr/we/dat = master x inputs.
  - s_wb_cyc_o = mx_cyc | (cnt≠0).
  - s_wb_stb_o = mx_cyc & mx_stb & (cnt≠max).
- Owner x: mx_stall_o = s_wb_stall_i | (cnt==max); mx_ack_o = s_wb_ack_i.
- Non-owner, and both masters in IDLE: stall_o=1, ack_o=0.
- m0_wb_data_o = m1_wb_data_o = s_wb_data_i (broadcast; qualified by ack).
- cnt:
  - +1 on accepted request (s_stb_o & !s_stall_i).
  - −1 on s_wb_ack_i.
  - Both in the same cycle: unchanged.
  - Never exceeds max; never wraps below 0. A stray ack at cnt=0 is forwarded to the owner, and cnt stays 0.
- Release: in GNTx when mx_cyc=0 and cnt=0 (after this cycle's update), set last=x. Next state is GNTy if my_cyc=1, else IDLE.
- Owner dropping cyc with cnt≠0 (protocol violation): keep the grant and s_wb_cyc_o=1 until cnt reaches 0, with stb=0.
- rst_i mid-transaction: next cycle returns to IDLE, cnt=0, all slave outputs low. Pending acks after reset are dropped (ack_o=0 in IDLE).

## Timing
- Grant latency: 1 cycle. A master's cyc seen in IDLE at edge N gives the grant at N+1; its first stb reaches the slave in cycle N+1.
- Once granted: stall, ack and data pass through combinationally (0 cycles). Addr/stb to the slave are combinational from the owner.
- Handoff: owner's last ack and cyc=0 in cycle N, other master requesting → other is owner in N+1 with no IDLE bubble.
- Back-to-back transfers: 1 per cycle while s_wb_stall_i=0 and cnt<max.
- Stability: while owner stb=1 and stall_o=1, the arbiter must not change state or owner.
- Outputs at reset: s_wb_cyc_o=0, s_wb_stb_o=0, m0/m1_stall_o=1, m0/m1_ack_o=0, grant_o=00.

## Test plan
- Single master: m0 issues 4 reads at addr 0x0000–0x0003, slave acks 1 cycle later → grant_o=01 one cycle after cyc; 4 acks reach m0 only; cnt returns to 0; IDLE after cyc drops.
- Tie after reset: both cyc=1 in the same cycle → m0 granted. After m0 releases, m1 is granted the next cycle (no IDLE). Tie again → m1 loses to m0 only if last=1, otherwise alternates.
- Pending acks: m0 drops cyc with cnt=2, m1 requesting → m1 not granted and s_wb_cyc_o=1 until the second ack; m1 granted the cycle after cnt reaches 0.
- Saturation (CNT_WIDTH=2): slave never acks, m1 strobes continuously → 3 requests accepted, then m1_stall_o=1 and s_wb_stb_o=0; one ack → exactly one more accepted.
- Stray ack: s_wb_ack_i=1 in GNT0 with cnt=0 → m0_wb_ack_o=1, cnt stays 0, no underflow.
- Reset mid-burst: rst_i=1 with cnt=3 in GNT1 → next cycle IDLE, grant_o=00, cnt=0; late slave acks give m0/m1_ack_o=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter: FETCH (m0) and MEMORY (m1) share one slave port.
// Ownership is locked per cycle, round-robin on ties, and held until every accepted request is acked.
module wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_wb_cyc_i,
    input  logic                  m0_wb_stb_i,
    input  logic                  m0_wb_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_wb_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wb_dat_i,
    output logic                  m0_wb_stall_o,
    output logic                  m0_wb_ack_o,
    output logic [DATA_WIDTH-1:0] m0_wb_data_o,
    input  logic                  m1_wb_cyc_i,
    input  logic                  m1_wb_stb_i,
    input  logic                  m1_wb_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_wb_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wb_dat_i,
    output logic                  m1_wb_stall_o,
    output logic                  m1_wb_ack_o,
    output logic [DATA_WIDTH-1:0] m1_wb_data_o,
    output logic                  s_wb_cyc_o,
    output logic                  s_wb_stb_o,
    output logic                  s_wb_we_o,
    output logic [ADDR_WIDTH-1:0] s_wb_addr_o,
    output logic [DATA_WIDTH-1:0] s_wb_dat_o,
    input  logic                  s_wb_stall_i,
    input  logic                  s_wb_ack_i,
    input  logic [DATA_WIDTH-1:0] s_wb_data_i,
    output logic [1:0]            grant_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_q, last_d;   // 0: m0 served last, 1: m1 served last
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   cnt_zero, cnt_full, accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m0_wb_data_o = s_wb_data_i;
    assign m1_wb_data_o = s_wb_data_i;

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        s_wb_cyc_o    = 1'b0;
        s_wb_stb_o    = 1'b0;
        s_wb_we_o     = 1'b0;
        s_wb_addr_o   = '0;
        s_wb_dat_o    = '0;
        m0_wb_stall_o = 1'b1;
        m0_wb_ack_o   = 1'b0;
        m1_wb_stall_o = 1'b1;
        m1_wb_ack_o   = 1'b0;
        grant_o       = 2'b00;
        cnt_zero      = (cnt_q == '0);
        cnt_full      = (cnt_q == CNT_MAX);

        unique case (state_q)
            IDLE: begin
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_wb_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_wb_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                s_wb_cyc_o    = m0_wb_cyc_i | ~cnt_zero;
                s_wb_stb_o    = m0_wb_cyc_i & m0_wb_stb_i & ~cnt_full;
                s_wb_we_o     = m0_wb_we_i;
                s_wb_addr_o   = m0_wb_addr_i;
                s_wb_dat_o    = m0_wb_dat_i;
                m0_wb_stall_o = s_wb_stall_i | cnt_full;
                m0_wb_ack_o   = s_wb_ack_i;
                grant_o       = 2'b01;
            end
            GNT1: begin
                s_wb_cyc_o    = m1_wb_cyc_i | ~cnt_zero;
                s_wb_stb_o    = m1_wb_cyc_i & m1_wb_stb_i & ~cnt_full;
                s_wb_we_o     = m1_wb_we_i;
                s_wb_addr_o   = m1_wb_addr_i;
                s_wb_dat_o    = m1_wb_dat_i;
                m1_wb_stall_o = s_wb_stall_i | cnt_full;
                m1_wb_ack_o   = s_wb_ack_i;
                grant_o       = 2'b10;
            end
            default: state_d = IDLE;
        endcase

        // Outstanding count; a stray ack at zero is forwarded but never underflows.
        accept = s_wb_stb_o & ~s_wb_stall_i;
        if (state_q != IDLE) begin
            if (accept && !s_wb_ack_i) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end else if (!accept && s_wb_ack_i && !cnt_zero) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end

        // Release only once the owner has dropped cyc and nothing is left in flight.
        if (state_q == GNT0 && !m0_wb_cyc_i && cnt_d == '0) begin
            last_d  = 1'b0;
            state_d = m1_wb_cyc_i ? GNT1 : IDLE;
        end else if (state_q == GNT1 && !m1_wb_cyc_i && cnt_d == '0) begin
            last_d  = 1'b1;
            state_d = m0_wb_cyc_i ? GNT0 : IDLE;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized bench for wb_arbiter, compared each cycle with an owner/outstanding-count model.
module tb_wb_arbiter;

    localparam int MAXO = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mcyc  [2];
    logic        mstb  [2];
    logic        mwe   [2];
    logic [15:0] maddr [2];
    logic [15:0] mdat  [2];
    logic        m0_stall, m0_ack, m1_stall, m1_ack;
    logic [15:0] m0_data, m1_data;
    logic        s_cyc, s_stb, s_we;
    logic [15:0] s_addr, s_dat;
    logic        s_stall, s_ack;
    logic [15:0] s_data;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    // Reference model: whether someone owns the bus, who, who was served last, requests in flight.
    bit busy;
    bit ow;
    bit last_m;
    int outs;

    always #5 clk = ~clk;

    wb_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .CNT_WIDTH(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_wb_cyc_i(mcyc[0]), .m0_wb_stb_i(mstb[0]), .m0_wb_we_i(mwe[0]),
        .m0_wb_addr_i(maddr[0]), .m0_wb_dat_i(mdat[0]),
        .m0_wb_stall_o(m0_stall), .m0_wb_ack_o(m0_ack), .m0_wb_data_o(m0_data),
        .m1_wb_cyc_i(mcyc[1]), .m1_wb_stb_i(mstb[1]), .m1_wb_we_i(mwe[1]),
        .m1_wb_addr_i(maddr[1]), .m1_wb_dat_i(mdat[1]),
        .m1_wb_stall_o(m1_stall), .m1_wb_ack_o(m1_ack), .m1_wb_data_o(m1_data),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_addr_o(s_addr), .s_wb_dat_o(s_dat),
        .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_data_i(s_data),
        .grant_o(grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model on the edge.
    task automatic tick();
        logic        e_scyc, e_sstb, e_swe, full, acc;
        logic [15:0] e_addr, e_dat;
        logic [1:0]  e_st, e_ak, e_gnt;
        #1;
        e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_addr = '0; e_dat = '0;
        e_st = 2'b11; e_ak = 2'b00; e_gnt = 2'b00; full = 1'b0;
        if (busy) begin
            full      = (outs == MAXO);
            e_scyc    = mcyc[ow] || (outs != 0);
            e_sstb    = mcyc[ow] && mstb[ow] && !full;
            e_swe     = mwe[ow];
            e_addr    = maddr[ow];
            e_dat     = mdat[ow];
            e_st[ow]  = s_stall || full;
            e_ak[ow]  = s_ack;
            e_gnt[ow] = 1'b1;
        end
        chk("grant",    32'(grant),    32'(e_gnt));
        chk("s_cyc",    32'(s_cyc),    32'(e_scyc));
        chk("s_stb",    32'(s_stb),    32'(e_sstb));
        chk("s_we",     32'(s_we),     32'(e_swe));
        chk("s_addr",   32'(s_addr),   32'(e_addr));
        chk("s_dat",    32'(s_dat),    32'(e_dat));
        chk("m0_stall", 32'(m0_stall), 32'(e_st[0]));
        chk("m1_stall", 32'(m1_stall), 32'(e_st[1]));
        chk("m0_ack",   32'(m0_ack),   32'(e_ak[0]));
        chk("m1_ack",   32'(m1_ack),   32'(e_ak[1]));
        chk("m0_data",  32'(m0_data),  32'(s_data));
        chk("m1_data",  32'(m1_data),  32'(s_data));
        @(posedge clk);
        if (rst) begin
            busy = 1'b0; last_m = 1'b1; outs = 0;
        end else if (!busy) begin
            if (mcyc[0] && mcyc[1]) begin
                busy = 1'b1; ow = ~last_m;
            end else if (mcyc[0]) begin
                busy = 1'b1; ow = 1'b0;
            end else if (mcyc[1]) begin
                busy = 1'b1; ow = 1'b1;
            end
        end else begin
            acc = e_sstb && !s_stall;
            if (acc && !s_ack) outs++;
            else if (!acc && s_ack && outs > 0) outs--;
            if (!mcyc[ow] && outs == 0) begin
                last_m = ow;
                busy   = mcyc[~ow];
                ow     = ~ow;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        busy = 1'b0; ow = 1'b0; last_m = 1'b1; outs = 0;
        rst = 1'b1; s_stall = 1'b0; s_ack = 1'b0; s_data = 16'h5a5a;
        for (int k = 0; k < 2; k++) begin
            mcyc[k] = 1'b0; mstb[k] = 1'b0; mwe[k] = 1'b0; maddr[k] = '0; mdat[k] = '0;
        end
        @(negedge clk);

        // Reset state
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'd0);
        rst = 1'b0;

        // Single master: four reads, slave acks one cycle later
        mcyc[0] = 1'b1; tick();
        chk("sm_grant", 32'(grant), 32'd1);
        for (int i = 0; i < 4; i++) begin
            mstb[0] = 1'b1; maddr[0] = 16'(i); s_ack = (i > 0); tick();
        end
        mstb[0] = 1'b0; s_ack = 1'b1; tick();
        s_ack = 1'b0; mcyc[0] = 1'b0; tick();
        chk("sm_idle", 32'(grant), 32'd0);

        // Ties after reset: m0 first, then handoff without a bubble, then alternation
        rst = 1'b1; tick(); rst = 1'b0;
        mcyc[0] = 1'b1; mcyc[1] = 1'b1; tick();
        chk("tie_m0", 32'(grant), 32'd1);
        mstb[0] = 1'b1; tick();
        mstb[0] = 1'b0; mcyc[0] = 1'b0; s_ack = 1'b1; tick();
        chk("handoff_m1", 32'(grant), 32'd2);
        s_ack = 1'b0; mstb[1] = 1'b1; tick();
        mstb[1] = 1'b0; mcyc[1] = 1'b0; s_ack = 1'b1; tick();
        chk("m1_rel_idle", 32'(grant), 32'd0);
        s_ack = 1'b0; mcyc[0] = 1'b1; mcyc[1] = 1'b1; tick();
        chk("tie2_m0", 32'(grant), 32'd1);
        mcyc[0] = 1'b0; tick();
        chk("tie2_m1", 32'(grant), 32'd2);
        mcyc[0] = 1'b1; mcyc[1] = 1'b0; tick();
        chk("back_m0", 32'(grant), 32'd1);
        mcyc[0] = 1'b0; tick();
        mcyc[0] = 1'b1; mcyc[1] = 1'b1; tick();
        chk("tie3_m1", 32'(grant), 32'd2);
        mcyc[0] = 1'b0; mcyc[1] = 1'b0; tick();

        // Pending acks: m0 drops cyc with two in flight while m1 waits
        mcyc[0] = 1'b1; tick();
        mstb[0] = 1'b1; tick(); tick();
        mstb[0] = 1'b0; mcyc[0] = 1'b0; mcyc[1] = 1'b1; tick();
        chk("pend_grant", 32'(grant), 32'd1);
        chk("pend_scyc",  32'(s_cyc), 32'd1);
        s_ack = 1'b1; tick();
        chk("pend_grant2", 32'(grant), 32'd1);
        tick();
        chk("pend_m1", 32'(grant), 32'd2);
        s_ack = 1'b0;

        // Saturation: slave never acks, m1 strobes continuously
        mstb[1] = 1'b1; tick(); tick(); tick();
        chk("sat_stall", 32'(m1_stall), 32'd1);
        chk("sat_stb",   32'(s_stb),    32'd0);
        tick();
        s_ack = 1'b1; tick();
        s_ack = 1'b0; tick();
        chk("sat_stall2", 32'(m1_stall), 32'd1);

        // Reset mid-burst, then late acks must not reach either master
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rmid_grant", 32'(grant), 32'd0);
        mcyc[1] = 1'b0; mstb[1] = 1'b0; s_ack = 1'b1; tick();
        chk("rmid_ack0", 32'(m0_ack), 32'd0);
        chk("rmid_ack1", 32'(m1_ack), 32'd0);
        tick();

        // Stray ack while owned with nothing outstanding
        s_ack = 1'b0; mcyc[0] = 1'b1; tick();
        s_ack = 1'b1; tick();
        chk("stray_ack", 32'(m0_ack), 32'd1);
        s_ack = 1'b0; mcyc[0] = 1'b0; tick();
        chk("stray_idle", 32'(grant), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 7) == 0) mcyc[k] = ~mcyc[k];
                mstb[k]  = ($urandom_range(0, 9) < 7);
                mwe[k]   = 1'($urandom);
                maddr[k] = 16'($urandom);
                mdat[k]  = 16'($urandom);
            end
            s_stall = ($urandom_range(0, 3) == 0);
            s_ack   = ($urandom_range(0, 2) == 0);
            s_data  = 16'($urandom);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
